// File: rtl/ddr_cmd_arbiter.sv
// Two-master round-robin arbiter for the shared DDR command path.
// Read returns are steered back to their issuer via an owner-tag FIFO.
module ddr_cmd_arbiter #(
  parameter int TAG_DEPTH = 8,
  parameter int TAG_AW    = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_read,
  input  logic [25:0]       m0_addr,
  input  logic [127:0]      m0_wdata,
  output logic              m0_wdRd,
  output logic              m0_ack,
  output logic              m0_rdValid,
  output logic              m0_rdLast,
  output logic [127:0]      m0_rdData,
  input  logic              m1_req,
  input  logic              m1_read,
  input  logic [25:0]       m1_addr,
  input  logic [127:0]      m1_wdata,
  output logic              m1_wdRd,
  output logic              m1_ack,
  output logic              m1_rdValid,
  output logic              m1_rdLast,
  output logic [127:0]      m1_rdData,
  input  logic              afFull,
  input  logic              wbFull,
  input  logic              rbEmpty,
  input  logic [127:0]      readData,
  output logic              wrAF,
  output logic              afRead,
  output logic [25:0]       afAddress,
  output logic              wrWB,
  output logic [127:0]      writeData,
  output logic              rdRB,
  output logic [TAG_AW:0]   outstanding,
  output logic              rbOrphan
);

  typedef enum logic {
    IDLE,
    WR2
  } state_e;

  localparam logic [TAG_AW:0] DEPTH = (TAG_AW + 1)'(TAG_DEPTH);

  state_e               state_q, state_d;
  logic                 lastGrant_q, lastGrant_d;
  logic                 owner_q, owner_d;
  logic                 rbHalf_q, rbHalf_d;
  logic                 rbOrphan_q, rbOrphan_d;
  logic [TAG_DEPTH-1:0] tag_q;
  logic [TAG_AW-1:0]    wptr_q, rptr_q;
  logic [TAG_AW:0]      count_q, count_d;

  logic         push, pop, head;
  logic         win, win_any, win_read;
  logic [25:0]  win_addr, own_addr;
  logic [127:0] win_wdata, own_wdata;

  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      m0_req && m1_req:  win = ~lastGrant_q;
      m1_req && !m0_req: win = 1'b1;
      default:           win = 1'b0;
    endcase
    win_any   = m0_req | m1_req;
    win_read  = win ? m1_read  : m0_read;
    win_addr  = win ? m1_addr  : m0_addr;
    win_wdata = win ? m1_wdata : m0_wdata;
    own_addr  = owner_q ? m1_addr  : m0_addr;
    own_wdata = owner_q ? m1_wdata : m0_wdata;
  end

  // No skipping: a busy winner blocks the other master this cycle.
  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    owner_d     = owner_q;
    push        = 1'b0;
    m0_wdRd     = 1'b0;
    m1_wdRd     = 1'b0;
    m0_ack      = 1'b0;
    m1_ack      = 1'b0;
    wrAF        = 1'b0;
    afRead      = 1'b0;
    afAddress   = '0;
    wrWB        = 1'b0;
    writeData   = '0;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (win_any && win_read) begin
            if (!afFull && count_q < DEPTH) begin
              wrAF        = 1'b1;
              afRead      = 1'b1;
              afAddress   = win_addr;
              push        = 1'b1;
              lastGrant_d = win;
              m0_ack      = ~win;
              m1_ack      = win;
            end
          end else if (win_any && !wbFull) begin
            wrWB      = 1'b1;
            writeData = win_wdata;
            m0_wdRd   = ~win;
            m1_wdRd   = win;
            owner_d   = win;
            state_d   = WR2;
          end
        end
        WR2: begin
          if (!wbFull && !afFull) begin
            wrWB        = 1'b1;
            writeData   = own_wdata;
            wrAF        = 1'b1;
            afAddress   = own_addr;
            m0_wdRd     = ~owner_q;
            m1_wdRd     = owner_q;
            m0_ack      = ~owner_q;
            m1_ack      = owner_q;
            lastGrant_d = owner_q;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    head       = tag_q[rptr_q];
    rdRB       = !reset && !rbEmpty && (count_q != '0);
    pop        = rdRB && rbHalf_q;
    rbHalf_d   = rdRB ? ~rbHalf_q : rbHalf_q;
    rbOrphan_d = rbOrphan_q | (!rbEmpty && count_q == '0);
    m0_rdValid = rdRB && !head;
    m1_rdValid = rdRB && head;
    m0_rdLast  = m0_rdValid && rbHalf_q;
    m1_rdLast  = m1_rdValid && rbHalf_q;
    m0_rdData  = m0_rdValid ? readData : '0;
    m1_rdData  = m1_rdValid ? readData : '0;
    outstanding = reset ? '0 : count_q;
    rbOrphan    = reset ? 1'b0 : rbOrphan_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (TAG_AW + 1)'(1);
      2'b01:   count_d = count_q - (TAG_AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      owner_q     <= 1'b0;
      rbHalf_q    <= 1'b0;
      rbOrphan_q  <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      owner_q     <= owner_d;
      rbHalf_q    <= rbHalf_d;
      rbOrphan_q  <= rbOrphan_d;
      count_q     <= count_d;
      if (push) begin
        tag_q[wptr_q] <= win;
        wptr_q        <= wptr_q + TAG_AW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + TAG_AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// Randomized bench for ddr_cmd_arbiter: master/DDR drivers plus a
// negedge monitor that scores against a queue-based reference model.
module tb_ddr_cmd_arbiter;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         m0_req = 1'b0, m0_read = 1'b0;
  logic [25:0]  m0_addr = '0;
  logic [127:0] m0_wdata = '0;
  logic         m0_wdRd, m0_ack, m0_rdValid, m0_rdLast;
  logic [127:0] m0_rdData;
  logic         m1_req = 1'b0, m1_read = 1'b0;
  logic [25:0]  m1_addr = '0;
  logic [127:0] m1_wdata = '0;
  logic         m1_wdRd, m1_ack, m1_rdValid, m1_rdLast;
  logic [127:0] m1_rdData;
  logic         afFull = 1'b0, wbFull = 1'b0, rbEmpty = 1'b1;
  logic [127:0] readData = '0;
  logic         wrAF, afRead, wrWB, rdRB, rbOrphan;
  logic [25:0]  afAddress;
  logic [127:0] writeData;
  logic [3:0]   outstanding;

  always #5 clock = ~clock;

  ddr_cmd_arbiter #(.TAG_DEPTH(8), .TAG_AW(3)) dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_read(m0_read), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wdRd(m0_wdRd), .m0_ack(m0_ack),
    .m0_rdValid(m0_rdValid), .m0_rdLast(m0_rdLast), .m0_rdData(m0_rdData),
    .m1_req(m1_req), .m1_read(m1_read), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wdRd(m1_wdRd), .m1_ack(m1_ack),
    .m1_rdValid(m1_rdValid), .m1_rdLast(m1_rdLast), .m1_rdData(m1_rdData),
    .afFull(afFull), .wbFull(wbFull), .rbEmpty(rbEmpty),
    .readData(readData), .wrAF(wrAF), .afRead(afRead),
    .afAddress(afAddress), .wrWB(wrWB), .writeData(writeData),
    .rdRB(rdRB), .outstanding(outstanding), .rbOrphan(rbOrphan)
  );

  int checks = 0;
  int errors = 0;

  logic [1:0] en = '0;
  bit rd_only = 0, wr_only = 0, hold_rb = 0;
  bit force_orphan = 0, want_reset = 1, stall_wr2 = 0;
  int gen_pct = 50, p_af = 20, p_wb = 20, p_rb = 30;

  logic [1:0]   busy = '0, wsent = '0, ack_ev = '0, wd_ev = '0;
  logic         cur_read [2];
  logic [25:0]  cur_addr [2];
  logic [127:0] cur_w0 [2];
  logic [127:0] cur_w1 [2];
  int           seq [2];

  logic [128:0] exp_rd0[$];
  logic [128:0] exp_rd1[$];
  logic         own_q[$];
  logic [127:0] rbq[$];
  logic         lastg_m = 1'b1;
  logic [1:0]   wcnt_m = '0;
  bit           beat_m = 0, orph_m = 0;

  function automatic void chk(string name, logic [127:0] act,
                              logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [127:0] rd_word(logic [25:0] a, bit b);
    return {a, 5'd0, b, 32'hC0DE_0000 ^ {6'd0, a},
            64'(a) * 64'h9E37_79B9_7F4A_7C15};
  endfunction

  // Masters and DDR environment; inputs change 1 time unit after posedge.
  initial begin : drv
    seq[0] = 0;
    seq[1] = 0;
    forever begin
      @(posedge clock);
      #1;
      if (want_reset) begin
        reset = 1'b1;
        busy  = '0;
        wsent = '0;
      end else begin
        reset = 1'b0;
        for (int n = 0; n < 2; n++) begin
          if (ack_ev[n]) begin
            busy[n]  = 1'b0;
            wsent[n] = 1'b0;
          end else if (wd_ev[n]) begin
            wsent[n] = 1'b1;
          end
          if (busy[n] && cur_read[n] && $urandom_range(0, 39) == 0) begin
            busy[n] = 1'b0;
            if (n == 0) begin
              void'(exp_rd0.pop_back());
              void'(exp_rd0.pop_back());
            end else begin
              void'(exp_rd1.pop_back());
              void'(exp_rd1.pop_back());
            end
          end else if (!busy[n] && en[n] &&
                       int'($urandom_range(0, 99)) < gen_pct) begin
            busy[n] = 1'b1;
            seq[n]++;
            cur_read[n] = rd_only ? 1'b1 : wr_only ? 1'b0 :
                          1'($urandom_range(0, 1));
            cur_addr[n] = {1'(n), 25'(seq[n])};
            cur_w0[n] = {$urandom, $urandom, $urandom, $urandom};
            cur_w1[n] = {$urandom, $urandom, $urandom, $urandom};
            if (cur_read[n]) begin
              if (n == 0) begin
                exp_rd0.push_back({1'b0, rd_word(cur_addr[n], 1'b0)});
                exp_rd0.push_back({1'b1, rd_word(cur_addr[n], 1'b1)});
              end else begin
                exp_rd1.push_back({1'b0, rd_word(cur_addr[n], 1'b0)});
                exp_rd1.push_back({1'b1, rd_word(cur_addr[n], 1'b1)});
              end
            end
          end
        end
      end
      m0_req   = busy[0];
      m0_read  = busy[0] && cur_read[0];
      m0_addr  = busy[0] ? cur_addr[0] : '0;
      m0_wdata = !busy[0] ? '0 : wsent[0] ? cur_w1[0] : cur_w0[0];
      m1_req   = busy[1];
      m1_read  = busy[1] && cur_read[1];
      m1_addr  = busy[1] ? cur_addr[1] : '0;
      m1_wdata = !busy[1] ? '0 : wsent[1] ? cur_w1[1] : cur_w0[1];
      afFull   = int'($urandom_range(0, 99)) < p_af;
      wbFull   = (stall_wr2 && wsent[1]) ||
                 int'($urandom_range(0, 99)) < p_wb;
      rbEmpty  = force_orphan ? 1'b0 :
                 (hold_rb || rbq.size() == 0 ||
                  int'($urandom_range(0, 99)) < p_rb);
      readData = rbq.size() != 0 ? rbq[0] : '0;
    end
  end

  // Monitor: compares every cycle, then advances the reference model.
  always @(negedge clock) begin : mon
    int           osz;
    bit           exp_rdrb, inwr2, own, w, rd, g, ev;
    logic [1:0]   ea, ew;
    logic [128:0] ent;
    if (reset) begin
      chk("reset_outputs", 128'(|{m0_wdRd, m0_ack, m0_rdValid, m0_rdLast,
          m0_rdData, m1_wdRd, m1_ack, m1_rdValid, m1_rdLast, m1_rdData,
          wrAF, afRead, afAddress, wrWB, writeData, rdRB, outstanding,
          rbOrphan}), 128'd0);
      lastg_m = 1'b1;
      wcnt_m  = '0;
      beat_m  = 0;
      orph_m  = 0;
      own_q.delete();
      exp_rd0.delete();
      exp_rd1.delete();
      rbq.delete();
      ack_ev = '0;
      wd_ev  = '0;
    end else begin
      osz = own_q.size();
      exp_rdrb = !rbEmpty && osz != 0;
      chk("outstanding", 128'(outstanding), 128'(osz));
      chk("rbOrphan", 128'(rbOrphan), 128'(orph_m));
      chk("rdRB", 128'(rdRB), 128'(exp_rdrb));
      for (int n = 0; n < 2; n++) begin
        ev  = exp_rdrb ? (own_q[0] == 1'(n)) : 1'b0;
        ent = '0;
        if (ev) begin
          if (n == 0 && exp_rd0.size() != 0) ent = exp_rd0.pop_front();
          else if (n == 1 && exp_rd1.size() != 0) ent = exp_rd1.pop_front();
          else begin
            checks++;
            errors++;
            $display("FAIL rd_scoreboard: m%0d return with none expected", n);
          end
        end
        chk($sformatf("m%0d_rdValid", n),
            128'(n == 0 ? m0_rdValid : m1_rdValid), 128'(ev));
        chk($sformatf("m%0d_rdLast", n),
            128'(n == 0 ? m0_rdLast : m1_rdLast), 128'(ent[128]));
        chk($sformatf("m%0d_rdData", n),
            n == 0 ? m0_rdData : m1_rdData, ent[127:0]);
      end
      if (!rbEmpty && osz == 0) orph_m = 1;

      ea    = '0;
      ew    = '0;
      inwr2 = wcnt_m[0] | wcnt_m[1];
      own   = wcnt_m[1];
      if (inwr2) begin
        if (!wbFull && !afFull) begin
          ea[own] = 1'b1;
          ew[own] = 1'b1;
        end
      end else if (m0_req || m1_req) begin
        w  = (m0_req && m1_req) ? !lastg_m : m1_req;
        rd = w ? m1_read : m0_read;
        if (rd) begin
          if (!afFull && osz < 8) ea[w] = 1'b1;
        end else if (!wbFull) begin
          ew[w] = 1'b1;
        end
      end
      g = ea[1] | ew[1];
      chk("ack", 128'({m1_ack, m0_ack}), 128'(ea));
      chk("wdRd", 128'({m1_wdRd, m0_wdRd}), 128'(ew));
      chk("wrAF", 128'(wrAF), 128'(|ea));
      chk("afRead", 128'(afRead), 128'(|ea && !inwr2));
      chk("afAddress", 128'(afAddress), |ea ? 128'(cur_addr[g]) : 128'd0);
      chk("wrWB", 128'(wrWB), 128'(|ew));
      chk("writeData", writeData,
          !(|ew) ? 128'd0 : inwr2 ? cur_w1[g] : cur_w0[g]);

      if (|ea) lastg_m = ea[1];
      if (inwr2 && |ew) wcnt_m = '0;
      else if (|ew) wcnt_m[g] = 1'b1;
      if (exp_rdrb) begin
        if (beat_m) void'(own_q.pop_front());
        beat_m = !beat_m;
      end
      if (|ea && !inwr2) own_q.push_back(g);

      if (rdRB && rbq.size() != 0) void'(rbq.pop_front());
      if (wrAF && afRead) begin
        rbq.push_back(rd_word(afAddress, 1'b0));
        rbq.push_back(rd_word(afAddress, 1'b1));
      end
      ack_ev = {m1_ack, m0_ack};
      wd_ev  = {m1_wdRd, m0_wdRd};
    end
  end

  task automatic wait_idle();
    int k = 0;
    while ((busy != 0 || own_q.size() != 0 || rbq.size() != 0) &&
           k < 3000) begin
      @(posedge clock);
      k++;
    end
    checks++;
    if (k >= 3000) begin
      errors++;
      $display("FAIL drain: timed out with %0d reads outstanding",
               own_q.size());
    end
  endtask

  initial begin : ctrl
    int k;
    repeat (3) @(posedge clock);
    want_reset = 0;
    en = 2'b11;
    repeat (2000) @(posedge clock);

    rd_only = 1;
    hold_rb = 1;
    p_af    = 0;
    gen_pct = 100;
    repeat (40) @(posedge clock);
    @(negedge clock);
    #1;
    chk("tag_full_outstanding", 128'(outstanding), 128'd8);
    hold_rb = 0;
    rd_only = 0;
    p_af    = 20;
    gen_pct = 50;
    repeat (500) @(posedge clock);

    en = '0;
    wait_idle();
    force_orphan = 1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    chk("orphan_flag", 128'(rbOrphan), 128'd1);
    chk("orphan_rdRB", 128'(rdRB), 128'd0);
    @(posedge clock);
    force_orphan = 0;
    repeat (3) @(posedge clock);

    en        = 2'b10;
    wr_only   = 1;
    gen_pct   = 100;
    stall_wr2 = 1;
    k = 0;
    while (!wsent[1] && k < 200) begin
      @(posedge clock);
      k++;
    end
    checks++;
    if (!wsent[1]) begin
      errors++;
      $display("FAIL wr2_entry: m1 write word0 never consumed");
    end
    repeat (2) @(posedge clock);
    want_reset = 1;
    repeat (2) @(posedge clock);
    stall_wr2  = 0;
    wr_only    = 0;
    p_af       = 0;
    p_wb       = 0;
    en         = 2'b11;
    want_reset = 0;
    @(negedge clock);
    #1;
    chk("post_reset_grant",
        128'({m1_ack | m1_wdRd, m0_ack | m0_wdRd}), 128'd1);
    p_af = 20;
    p_wb = 20;
    repeat (1500) @(posedge clock);

    en = '0;
    wait_idle();
    repeat (4) @(posedge clock);
    chk("m0_returns_left", 128'(exp_rd0.size()), 128'd0);
    chk("m1_returns_left", 128'(exp_rd1.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
